// File: rtl/cory_merge4.sv
// Four-input round-robin merge onto one valid/data/ready stream.
// A 2-entry output FIFO decouples input readies from the downstream ready.
module cory_merge4 #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_a0_v,
  input  logic [N-1:0] i_a0_d,
  output logic         o_a0_r,
  input  logic         i_a1_v,
  input  logic [N-1:0] i_a1_d,
  output logic         o_a1_r,
  input  logic         i_a2_v,
  input  logic [N-1:0] i_a2_d,
  output logic         o_a2_r,
  input  logic         i_a3_v,
  input  logic [N-1:0] i_a3_d,
  output logic         o_a3_r,
  output logic         o_z_v,
  output logic [N-1:0] o_z_d,
  output logic [1:0]   o_z_s,
  input  logic         i_z_r
);

  logic [3:0]   in_v;
  logic [N-1:0] in_d [4];
  logic [3:0]   in_r;

  assign in_v    = {i_a3_v, i_a2_v, i_a1_v, i_a0_v};
  assign in_d[0] = i_a0_d;
  assign in_d[1] = i_a1_d;
  assign in_d[2] = i_a2_d;
  assign in_d[3] = i_a3_d;
  assign o_a0_r  = in_r[0];
  assign o_a1_r  = in_r[1];
  assign o_a2_r  = in_r[2];
  assign o_a3_r  = in_r[3];

  logic [1:0]   ptr_reg;
  logic [1:0]   cnt_reg;
  logic [1:0]   cnt_next;
  logic         wr_reg;
  logic         rd_reg;
  logic [N+1:0] mem_reg [2];

  logic [1:0] pick;
  logic [1:0] idx;
  logic       found;
  logic       can_push;
  logic       push;
  logic       pop;

  // Scan from ptr upward; the first valid input wins, otherwise pick stays at ptr.
  always_comb begin
    pick  = ptr_reg;
    idx   = ptr_reg;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_reg + 2'(k);
      if (!found && in_v[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign can_push = !reset && (cnt_reg != 2'd2);
  assign push     = can_push && found;
  assign pop      = o_z_v && i_z_r;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ready
      assign in_r[gi] = can_push && (pick == 2'(gi));
    end
  endgenerate

  always_comb begin
    cnt_next = cnt_reg;
    if (push && !pop) begin
      cnt_next = cnt_reg + 2'd1;
    end else if (pop && !push) begin
      cnt_next = cnt_reg - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg    <= 2'd0;
      cnt_reg    <= 2'd0;
      wr_reg     <= 1'b0;
      rd_reg     <= 1'b0;
      mem_reg[0] <= '0;
      mem_reg[1] <= '0;
    end else begin
      cnt_reg <= cnt_next;
      if (push) begin
        mem_reg[wr_reg] <= {pick, in_d[pick]};
        wr_reg          <= !wr_reg;
        ptr_reg         <= pick + 2'd1;
      end
      if (pop) begin
        rd_reg <= !rd_reg;
      end
    end
  end

  // Head entry only moves on pop, so it stays stable while stalled.
  assign o_z_v = (cnt_reg != 2'd0);
  assign o_z_d = mem_reg[rd_reg][N-1:0];
  assign o_z_s = mem_reg[rd_reg][N+1:N];

endmodule

// File: tb/tb_cory_merge4.sv
// Randomized and directed bench for cory_merge4 against a queue-based
// reference model of the round-robin merge.
module tb_cory_merge4;

  logic       clk;
  logic       reset;
  logic [3:0] v;
  logic [7:0] d [4];
  logic [3:0] r;
  logic       z_v;
  logic [7:0] z_d;
  logic [1:0] z_s;
  logic       z_r;

  cory_merge4 #(.N(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .i_a0_v (v[0]), .i_a0_d (d[0]), .o_a0_r (r[0]),
    .i_a1_v (v[1]), .i_a1_d (d[1]), .o_a1_r (r[1]),
    .i_a2_v (v[2]), .i_a2_d (d[2]), .o_a2_r (r[2]),
    .i_a3_v (v[3]), .i_a3_d (d[3]), .o_a3_r (r[3]),
    .o_z_v  (z_v),
    .o_z_d  (z_d),
    .o_z_s  (z_s),
    .i_z_r  (z_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: beats in accept order, and the round-robin start point.
  logic [9:0] q_m [$];
  int         ptr_m;
  int         seq_m [4];
  logic       after_reset;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check, then advance the model at posedge.
  // counted_data=1 gives input x the data 0x10*x + k for its k-th accepted beat.
  task automatic cycle(input logic [3:0] vmask, input logic zr, input logic rst,
                       input logic counted_data);
    logic [3:0] exp_r;
    int         pick;
    bit         found;
    bit         acc;
    bit         pop;
    reset = rst;
    v     = vmask;
    z_r   = zr;
    for (int x = 0; x < 4; x++) begin
      d[x] = counted_data ? 8'(16 * x + (seq_m[x] % 16)) : 8'($urandom_range(0, 255));
    end
    #1;
    exp_r = 4'b0000;
    pick  = ptr_m;
    found = 0;
    for (int k = 0; k < 4; k++) begin
      int x;
      x = (ptr_m + k) % 4;
      if (!found && v[x]) begin
        pick  = x;
        found = 1;
      end
    end
    if (!rst && q_m.size() < 2) exp_r[pick] = 1'b1;
    check_eq("ready", 32'(r), 32'(exp_r));
    check_eq("z_v", 32'(z_v), 32'(q_m.size() != 0));
    if (q_m.size() != 0) begin
      check_eq("z_d", 32'(z_d), 32'(q_m[0][7:0]));
      check_eq("z_s", 32'(z_s), 32'(q_m[0][9:8]));
    end
    if (after_reset) begin
      check_eq("rst_z_d", 32'(z_d), 32'd0);
      check_eq("rst_z_s", 32'(z_s), 32'd0);
    end
    acc = found && exp_r[pick];
    pop = (q_m.size() != 0) && zr;
    @(posedge clk);
    if (rst) begin
      q_m.delete();
      ptr_m       = 0;
      after_reset = 1'b1;
    end else begin
      after_reset = 1'b0;
      if (pop) begin
        $display("beat out: src=%0d data=0x%02h", q_m[0][9:8], q_m[0][7:0]);
        void'(q_m.pop_front());
      end
      if (acc) begin
        q_m.push_back({2'(pick), d[pick]});
        seq_m[pick]++;
        ptr_m = (pick + 1) % 4;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    v     = 4'b0000;
    z_r   = 1'b0;
    for (int x = 0; x < 4; x++) begin
      d[x]     = 8'h00;
      seq_m[x] = 0;
    end
    ptr_m       = 0;
    after_reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    after_reset = 1'b1;

    // All inputs valid at full rate: strict 0,1,2,3 rotation.
    for (int i = 0; i < 20; i++) cycle(4'b1111, 1'b1, 1'b0, 1'b1);
    // Only input 2 valid, back-to-back.
    for (int i = 0; i < 12; i++) cycle(4'b0100, 1'b1, 1'b0, 1'b1);
    // Output stalled for 5 cycles with everyone valid, then released.
    for (int i = 0; i < 5; i++)  cycle(4'b1111, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cycle(4'b1111, 1'b1, 1'b0, 1'b1);
    // Drain, set ptr=3 via one beat from input 2, then a0+a3 contend across the wrap.
    for (int i = 0; i < 3; i++)  cycle(4'b0000, 1'b1, 1'b0, 1'b1);
    cycle(4'b0100, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)  cycle(4'b1001, 1'b1, 1'b0, 1'b1);
    // Single source at full rate keeps one beat in flight (push and pop together).
    for (int i = 0; i < 3; i++)  cycle(4'b0000, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) cycle(4'b0001, 1'b1, 1'b0, 1'b1);
    // Fill the buffer, reset while full, then restart with everyone valid.
    for (int i = 0; i < 4; i++)  cycle(4'b1111, 1'b0, 1'b0, 1'b1);
    cycle(4'b1111, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++)  cycle(4'b1111, 1'b1, 1'b0, 1'b1);

    // Random valids, random backpressure, occasional reset.
    for (int i = 0; i < 400; i++) begin
      cycle(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 59) == 0), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
